// File: rtl/i2c_byte_master_if.sv
// rtl/i2c_byte_master_if.sv - command handshake and open-drain pad bundle for i2c_byte_master
// Purpose: groups the command/response handshake and the split SCL/SDA pad signals.
// Signals:
//   i_cmd_valid/o_cmd_ready : command handshake (accepted when both high)
//   i_cmd[1:0]              : 00 START, 01 WRITE, 10 READ, 11 STOP
//   i_cmd_data[7:0]         : WRITE byte, MSB first
//   i_cmd_nack              : READ ack slot level (1 = NACK)
//   o_cmd_done              : one-cycle completion pulse
//   o_rd_data[7:0], o_nack  : READ byte / WRITE ack bit, valid with o_cmd_done
//   o_busy                  : bus owned (START done .. STOP done)
//   i2c_scl_*/i2c_sda_*     : pad level in, constant-0 out, tristate enable (1 = release)
// Modports: master = engine side, slave = command issuer and pad side.
`timescale 1ns/1ps
interface i2c_byte_master_if;
   logic       i_cmd_valid;
   logic       o_cmd_ready;
   logic [1:0] i_cmd;
   logic [7:0] i_cmd_data;
   logic       i_cmd_nack;
   logic       o_cmd_done;
   logic [7:0] o_rd_data;
   logic       o_nack;
   logic       o_busy;
   logic       i2c_scl_i;
   logic       i2c_scl_o;
   logic       i2c_scl_t;
   logic       i2c_sda_i;
   logic       i2c_sda_o;
   logic       i2c_sda_t;

   modport master (
      input  i_cmd_valid, i_cmd, i_cmd_data, i_cmd_nack, i2c_scl_i, i2c_sda_i,
      output o_cmd_ready, o_cmd_done, o_rd_data, o_nack, o_busy,
             i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t
   );

   modport slave (
      output i_cmd_valid, i_cmd, i_cmd_data, i_cmd_nack, i2c_scl_i, i2c_sda_i,
      input  o_cmd_ready, o_cmd_done, o_rd_data, o_nack, o_busy,
             i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t
   );
endinterface

// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - byte-level single-master I2C engine (START/WRITE/READ/STOP)
// Purpose: executes one bus command at a time, generating open-drain SCL/SDA with
//          quarter-bit timing, honouring slave clock stretching, and reporting
//          WRITE ack and READ data.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active high
//   bus  : i2c_byte_master_if.master (command handshake, results, pad signals)
// Parameters: CLK_FREQ (Hz), I2C_FREQ (Hz); quarter-bit = CLK_FREQ/(4*I2C_FREQ) clocks (>= 2).
`timescale 1ns/1ps
module i2c_byte_master #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int I2C_FREQ = 100_000
) (
   input  logic               clk,
   input  logic               rst,
   i2c_byte_master_if.master  bus
);
   localparam int QTR = CLK_FREQ / (4 * I2C_FREQ);
   localparam int QW  = $clog2(QTR);
   localparam logic [QW-1:0] QTR_LAST = QW'(QTR - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WRITE,
      S_READ,
      S_STOP
   } state_t;

   state_t     state;
   state_t     acc_state;
   logic [1:0] phase;
   logic [QW-1:0] qcnt;
   logic [3:0] bit_idx;
   logic [3:0] nxt_idx;
   logic [7:0] data_r;
   logic       nack_r;
   logic       scl_t_r;
   logic       sda_t_r;
   logic       ready_r;
   logic       done_r;
   logic       busy_r;
   logic [7:0] rd_r;
   logic       nack_q;
   logic       stretch;
   logic       qtr_end;

   // A slave holding SCL low during the released-high quarter freezes the count.
   assign stretch = (phase == 2'd2) && !bus.i2c_scl_i;
   assign qtr_end = (qcnt == QTR_LAST) && !stretch;
   assign nxt_idx = bit_idx + 4'd1;

   always_comb begin
      acc_state = S_START;
      case (bus.i_cmd)
         2'b00:   acc_state = S_START;
         2'b01:   acc_state = S_WRITE;
         2'b10:   acc_state = S_READ;
         default: acc_state = S_STOP;
      endcase
   end

   // SDA enable for bit slot idx: slots 0-7 carry data, slot 8 is the ack slot.
   function automatic logic bit_level(input state_t st, input logic [3:0] idx,
                                      input logic [7:0] d, input logic n);
      if (idx[3])
         return (st == S_READ) ? n : 1'b1;
      else
         return (st == S_WRITE) ? d[~idx[2:0]] : 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         phase   <= 2'd0;
         qcnt    <= '0;
         bit_idx <= 4'd0;
         data_r  <= 8'h00;
         nack_r  <= 1'b0;
         scl_t_r <= 1'b1;
         sda_t_r <= 1'b1;
         ready_r <= 1'b1;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         rd_r    <= 8'h00;
         nack_q  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (state == S_IDLE) begin
            if (bus.i_cmd_valid && ready_r) begin
               state   <= acc_state;
               phase   <= 2'd0;
               qcnt    <= '0;
               bit_idx <= 4'd0;
               data_r  <= bus.i_cmd_data;
               nack_r  <= bus.i_cmd_nack;
               ready_r <= 1'b0;
               // Lines for Q0 of the new command are set on the accepting edge.
               case (acc_state)
                  S_START: sda_t_r <= 1'b1;
                  S_STOP: begin
                     scl_t_r <= 1'b0;
                     sda_t_r <= 1'b0;
                  end
                  default: begin
                     scl_t_r <= 1'b0;
                     sda_t_r <= bit_level(acc_state, 4'd0, bus.i_cmd_data, bus.i_cmd_nack);
                  end
               endcase
            end
         end else if (!qtr_end) begin
            qcnt <= stretch ? '0 : qcnt + 1'b1;
         end else begin
            // Quarter boundary: registered line values are those of the next quarter.
            qcnt  <= '0;
            phase <= phase + 2'd1;
            case (state)
               S_START: begin
                  case (phase)
                     2'd0: scl_t_r <= 1'b1;
                     2'd1: sda_t_r <= 1'b0;
                     2'd2: scl_t_r <= 1'b0;
                     default: begin
                        busy_r  <= 1'b1;
                        state   <= S_IDLE;
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                     end
                  endcase
               end
               S_WRITE, S_READ: begin
                  // Last clock of Q2 is the sampling point.
                  if (phase == 2'd2) begin
                     if (state == S_READ && !bit_idx[3])
                        rd_r <= {rd_r[6:0], bus.i2c_sda_i};
                     if (state == S_WRITE && bit_idx[3])
                        nack_q <= bus.i2c_sda_i;
                  end
                  case (phase)
                     2'd1: scl_t_r <= 1'b1;
                     2'd3: begin
                        // SCL is pulled low after every bit, including the final one.
                        scl_t_r <= 1'b0;
                        if (bit_idx[3]) begin
                           state   <= S_IDLE;
                           done_r  <= 1'b1;
                           ready_r <= 1'b1;
                        end else begin
                           bit_idx <= nxt_idx;
                           sda_t_r <= bit_level(state, nxt_idx, data_r, nack_r);
                        end
                     end
                     default: ;
                  endcase
               end
               S_STOP: begin
                  case (phase)
                     2'd0: scl_t_r <= 1'b1;
                     2'd1: sda_t_r <= 1'b1;
                     2'd3: begin
                        busy_r  <= 1'b0;
                        state   <= S_IDLE;
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                     end
                     default: ;
                  endcase
               end
               default: begin
                  state   <= S_IDLE;
                  ready_r <= 1'b1;
                  scl_t_r <= 1'b1;
                  sda_t_r <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.o_cmd_ready = ready_r;
   assign bus.o_cmd_done  = done_r;
   assign bus.o_rd_data   = rd_r;
   assign bus.o_nack      = nack_q;
   assign bus.o_busy      = busy_r;
   assign bus.i2c_scl_o   = 1'b0;
   assign bus.i2c_sda_o   = 1'b0;
   assign bus.i2c_scl_t   = scl_t_r;
   assign bus.i2c_sda_t   = sda_t_r;
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - self-checking bench for i2c_byte_master with a behavioural slave
`timescale 1ns/1ps
module tb_i2c_byte_master;
   localparam int CLK_FREQ = 4_000_000;
   localparam int I2C_FREQ = 100_000;
   localparam int QTR      = CLK_FREQ / (4 * I2C_FREQ);
   localparam int CTRL_CLK = 4 * QTR;
   localparam int BYTE_CLK = 36 * QTR;
   localparam int STRETCH  = 300;
   localparam logic [1:0] C_START = 2'b00, C_WRITE = 2'b01, C_READ = 2'b10, C_STOP = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   i2c_byte_master_if bus ();
   i2c_byte_master #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- bus / slave model ----------------
   int         slave_mode = 0;   // 0 idle, 1 write target (acks), 2 read target
   logic [7:0] slave_byte = 8'h00;
   logic       slave_nack = 1'b1;
   logic       slave_sda;
   int         hold_cnt = 0;
   logic       stretch_req = 1'b0;
   logic       stretch_used = 1'b0;
   int         fall_cnt = 0, fall_base = 0, start_cnt = 0, stop_cnt = 0;
   longint     cyc = 0;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   logic       rise_sda[$];
   logic       rise_sdat[$];
   longint     rise_cyc[$];
   logic       scl_line, sda_line;

   always_comb begin
      int idx;
      idx = fall_cnt - fall_base;
      slave_sda = 1'b1;
      if (slave_mode == 2 && idx >= 0 && idx < 8)
         slave_sda = slave_byte[3'(7 - idx)];
      else if (slave_mode == 1 && idx == 8)
         slave_sda = slave_nack;
   end

   assign scl_line = (bus.i2c_scl_t ? 1'b1 : bus.i2c_scl_o) & (hold_cnt == 0);
   assign sda_line = (bus.i2c_sda_t ? 1'b1 : bus.i2c_sda_o) & slave_sda;
   assign bus.i2c_scl_i = scl_line;
   assign bus.i2c_sda_i = sda_line;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
      if (prev_scl && !scl_line) begin
         fall_cnt <= fall_cnt + 1;
         // Grab SCL from Q0 of bit 3 so the extra time lands in Q2.
         if (stretch_req && !stretch_used && (fall_cnt + 1 - fall_base) == 3) begin
            hold_cnt     <= STRETCH + 2 * QTR;
            stretch_used <= 1'b1;
         end
      end
      if (!prev_scl && scl_line) begin
         rise_sda.push_back(sda_line);
         rise_sdat.push_back(bus.i2c_sda_t);
         rise_cyc.push_back(cyc);
      end
      if (prev_scl && scl_line && prev_sda && !sda_line) start_cnt <= start_cnt + 1;
      if (prev_scl && scl_line && !prev_sda && sda_line) stop_cnt <= stop_cnt + 1;
      prev_scl <= scl_line;
      prev_sda <= sda_line;
   end

   // ---------------- checking helpers ----------------
   int n_pass = 0, n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
   endtask

   task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic n,
                          output longint dur);
      int k;
      bit seen;
      longint t0;
      @(negedge clk);
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd       = c;
      bus.i_cmd_data  = d;
      bus.i_cmd_nack  = n;
      k = 0;
      while (!bus.o_cmd_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("ready_before_accept", bus.o_cmd_ready, 1);
      @(posedge clk);
      #1;
      bus.i_cmd_valid = 1'b0;
      bus.i_cmd_data  = ~d;       // must already be latched
      bus.i_cmd_nack  = ~n;
      t0 = cyc;
      fall_base = fall_cnt;
      rise_sda.delete();
      rise_sdat.delete();
      rise_cyc.delete();
      @(negedge clk);
      check("ready_drop", bus.o_cmd_ready, 0);
      seen = 0;
      for (int i = 0; i < BYTE_CLK + 2000; i++) begin
         if (bus.o_cmd_done) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      check("done_seen", seen, 1);
      dur = cyc - t0;
      @(negedge clk);
      check("done_one_cycle", bus.o_cmd_done, 0);
      check("ready_after_done", bus.o_cmd_ready, 1);
   endtask

   // Bus-level view of one byte: 8 data bits then the ack slot.
   task automatic check_bits(input logic [1:0] c, input logic [7:0] d, input logic n,
                             input logic [7:0] sbyte, input logic snack);
      logic [7:0] got;
      check("rise_count", rise_sda.size(), 9);
      if (rise_sda.size() == 9) begin
         got = 8'h00;
         for (int i = 0; i < 8; i++) got = {got[6:0], rise_sda[i]};
         if (c == C_WRITE) begin
            check("wr_byte_on_bus", got, d);
            check("wr_ack_released", rise_sdat[8], 1);
            check("wr_ack_line", rise_sda[8], snack);
         end else begin
            check("rd_byte_on_bus", got, sbyte);
            check("rd_ack_drive", rise_sdat[8], n);
         end
         check("scl_period", 32'(rise_cyc[1] - rise_cyc[0]), 4 * QTR);
      end
   endtask

   typedef struct {
      logic [1:0] cmd;
      logic [7:0] data;
      logic       cmd_nack;
      logic [7:0] sbyte;
      logic       snack;
      logic [7:0] exp_rd;
      logic       exp_nack;
      logic       exp_busy;
   } vec_t;

   vec_t vecs[8];

   task automatic apply(input vec_t v);
      longint dur;
      int s0, p0;
      slave_mode = (v.cmd == C_WRITE) ? 1 : (v.cmd == C_READ) ? 2 : 0;
      slave_byte = v.sbyte;
      slave_nack = v.snack;
      s0 = start_cnt;
      p0 = stop_cnt;
      run_cmd(v.cmd, v.data, v.cmd_nack, dur);
      check("duration", 32'(dur), (v.cmd == C_WRITE || v.cmd == C_READ) ? BYTE_CLK : CTRL_CLK);
      check("rd_data", bus.o_rd_data, v.exp_rd);
      check("nack", bus.o_nack, v.exp_nack);
      check("busy", bus.o_busy, v.exp_busy);
      check("start_cond", start_cnt - s0, (v.cmd == C_START) ? 1 : 0);
      check("stop_cond", stop_cnt - p0, (v.cmd == C_STOP) ? 1 : 0);
      if (v.cmd == C_WRITE || v.cmd == C_READ)
         check_bits(v.cmd, v.data, v.cmd_nack, v.sbyte, v.snack);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      longint dur;
      int k, s0;
      bit any_done;
      logic [7:0] m_rd;
      logic m_nack;
      vec_t v;

      vecs[0] = '{C_START, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
      vecs[1] = '{C_WRITE, 8'hA0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
      vecs[2] = '{C_WRITE, 8'h3C, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
      vecs[3] = '{C_READ,  8'h00, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1};
      vecs[4] = '{C_READ,  8'h00, 1'b0, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1};
      vecs[5] = '{C_START, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b1};
      vecs[6] = '{C_WRITE, 8'h81, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b1};
      vecs[7] = '{C_STOP,  8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0};

      bus.i_cmd_valid = 1'b0;
      bus.i_cmd       = 2'b00;
      bus.i_cmd_data  = 8'h00;
      bus.i_cmd_nack  = 1'b0;

      // Reset for 3 clocks
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("reset_no_done", bus.o_cmd_done, 0);
      end
      check("reset_scl_t", bus.i2c_scl_t, 1);
      check("reset_sda_t", bus.i2c_sda_t, 1);
      check("reset_scl_o", bus.i2c_scl_o, 0);
      check("reset_sda_o", bus.i2c_sda_o, 0);
      check("reset_ready", bus.o_cmd_ready, 1);
      check("reset_busy", bus.o_busy, 0);
      check("reset_rd_data", bus.o_rd_data, 0);
      check("reset_nack", bus.o_nack, 0);
      rst = 1'b0;

      // Directed table
      for (int i = 0; i < 8; i++) apply(vecs[i]);
      check("stop_lines_released", {bus.i2c_scl_t, bus.i2c_sda_t}, 2'b11);

      // Clock stretch in Q2 of bit 3
      apply('{C_START, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b1});
      slave_mode = 1;
      slave_nack = 1'b0;
      stretch_req = 1'b1;
      run_cmd(C_WRITE, 8'h96, 1'b0, dur);
      stretch_req = 1'b0;
      check("stretch_applied", stretch_used, 1);
      check("stretch_duration", (dur >= BYTE_CLK + STRETCH - 1 && dur <= BYTE_CLK + STRETCH + 1), 1);
      check("stretch_nack", bus.o_nack, 0);
      check_bits(C_WRITE, 8'h96, 1'b0, 8'h00, 1'b0);
      apply('{C_STOP, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0});

      // Randomized transactions against a byte-level model
      m_rd = 8'h5A;
      m_nack = 1'b0;
      for (int it = 0; it < 10; it++) begin
         apply('{C_START, 8'h00, 1'b0, 8'h00, 1'b1, m_rd, m_nack, 1'b1});
         for (int op = 0; op < int'($urandom_range(1, 3)); op++) begin
            v.cmd      = ($urandom_range(0, 1) == 0) ? C_WRITE : C_READ;
            v.data     = 8'($urandom);
            v.cmd_nack = 1'($urandom);
            v.sbyte    = 8'($urandom);
            v.snack    = 1'($urandom);
            if (v.cmd == C_WRITE) m_nack = v.snack;
            else m_rd = v.sbyte;
            v.exp_rd   = m_rd;
            v.exp_nack = m_nack;
            v.exp_busy = 1'b1;
            apply(v);
            if ($urandom_range(0, 3) == 0)
               apply('{C_START, 8'h00, 1'b0, 8'h00, 1'b1, m_rd, m_nack, 1'b1});
         end
         apply('{C_STOP, 8'h00, 1'b0, 8'h00, 1'b1, m_rd, m_nack, 1'b0});
      end

      // Reset in the middle of bit 4 of a WRITE
      apply('{C_START, 8'h00, 1'b0, 8'h00, 1'b1, m_rd, m_nack, 1'b1});
      slave_mode = 1;
      slave_nack = 1'b0;
      @(negedge clk);
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd       = C_WRITE;
      bus.i_cmd_data  = 8'h55;
      @(posedge clk);
      #1;
      bus.i_cmd_valid = 1'b0;
      fall_base = fall_cnt;
      k = 0;
      while ((fall_cnt - fall_base) < 4 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("reached_bit4", (fall_cnt - fall_base) >= 4, 1);
      repeat (QTR) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_scl_t", bus.i2c_scl_t, 1);
      check("rst_mid_sda_t", bus.i2c_sda_t, 1);
      check("rst_mid_ready", bus.o_cmd_ready, 1);
      check("rst_mid_busy", bus.o_busy, 0);
      check("rst_mid_done", bus.o_cmd_done, 0);
      rst = 1'b0;
      slave_mode = 0;
      any_done = 0;
      repeat (BYTE_CLK) begin
         @(negedge clk);
         if (bus.o_cmd_done) any_done = 1;
      end
      check("rst_mid_no_done", any_done, 0);
      s0 = stop_cnt;
      apply('{C_START, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1});
      check("rst_mid_no_stop", stop_cnt - s0, 0);
      apply('{C_STOP, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
